// File: rtl/shot_link.sv
`default_nettype none
// ============================================================================
// Module   : shot_link
// Purpose  : Serial shot/reply link between two game boards: sends our shots,
//            answers the opponent's shots from the own-board lookup.
//            Optional macro SHOT_RETRY_EN enables reply timeout and resend.
// Revision : 1.0  initial release
// ============================================================================
module shot_link #(
    parameter int MSG_HOLD      = 1_100_000,
    parameter int REPLY_TIMEOUT = 6_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       addres_sent,
    input  logic [7:0] check_out,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] cell_addr,
    input  logic       cell_ship,
    output logic [1:0] msg_send,
    output logic [1:0] msg_in,
    output logic [7:0] check_in,
    output logic [3:0] hits_taken,
    output logic       fleet_lost,
    output logic       link_err
);

    // One counter width serves both the message-hold and reply timers.
    localparam int c_CNT_MAX = (MSG_HOLD > REPLY_TIMEOUT) ? MSG_HOLD : REPLY_TIMEOUT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_HOLD = c_CNT_W'(MSG_HOLD);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    localparam logic [7:0] c_HDR  = 8'hA5;
    localparam logic [7:0] c_MISS = 8'hC0;
    localparam logic [7:0] c_HIT  = 8'hC1;

    localparam logic [2:0] c_ST_IDLE       = 3'd0;
    localparam logic [2:0] c_ST_TX_HDR     = 3'd1;
    localparam logic [2:0] c_ST_TX_ADDR    = 3'd2;
    localparam logic [2:0] c_ST_WAIT_REPLY = 3'd3;
    localparam logic [2:0] c_ST_LOOKUP     = 3'd4;
    localparam logic [2:0] c_ST_TX_REPLY   = 3'd5;

    localparam logic       c_RX_IDLE = 1'b0;
    localparam logic       c_RX_ADDR = 1'b1;

    localparam logic [1:0] c_PH_WAIT  = 2'd0;
    localparam logic [1:0] c_PH_SKIP  = 2'd1;
    localparam logic [1:0] c_PH_DRAIN = 2'd2;

    logic [2:0]         r_state;
    logic [1:0]         r_tx_phase;
    logic               r_lookup_phase;
    logic               r_rx_state;
    logic               r_pend_valid;
    logic [7:0]         r_pend_addr;
    logic               r_req_valid;
    logic [7:0]         r_req_addr;
    logic [7:0]         r_shot_addr;
    logic               r_as_q;
    logic               r_tx_start;
    logic [7:0]         r_tx_data;
    logic [7:0]         r_cell_addr;
    logic [1:0]         r_msg_send;
    logic [1:0]         r_msg_in;
    logic [c_CNT_W-1:0] r_send_cnt;
    logic [c_CNT_W-1:0] r_in_cnt;
    logic [7:0]         r_check_in;
    logic [3:0]         r_hits;
    logic               r_fleet_lost;
    logic               r_link_err;
`ifdef SHOT_RETRY_EN
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(REPLY_TIMEOUT - 1);
    logic [c_CNT_W-1:0] r_wait_cnt;
    logic [1:0]         r_retry_cnt;
`endif

    logic w_edge;
    logic w_capture;
    logic w_tx_state;
    logic w_tx_done;

    assign w_edge     = addres_sent & ~r_as_q;
    assign w_capture  = (r_rx_state == c_RX_ADDR) & rx_valid;
    assign w_tx_state = (r_state == c_ST_TX_HDR) | (r_state == c_ST_TX_ADDR) |
                        (r_state == c_ST_TX_REPLY);
    assign w_tx_done  = (r_tx_phase == c_PH_DRAIN) & ~tx_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_ST_IDLE;
            r_tx_phase     <= c_PH_WAIT;
            r_lookup_phase <= 1'b0;
            r_rx_state     <= c_RX_IDLE;
            r_pend_valid   <= 1'b0;
            r_pend_addr    <= 8'h00;
            r_req_valid    <= 1'b0;
            r_req_addr     <= 8'h00;
            r_shot_addr    <= 8'h00;
            // A level already high when reset releases is not a new request.
            r_as_q         <= addres_sent;
            r_tx_start     <= 1'b0;
            r_tx_data      <= 8'h00;
            r_cell_addr    <= 8'h00;
            r_msg_send     <= 2'b00;
            r_msg_in       <= 2'b00;
            r_send_cnt     <= '0;
            r_in_cnt       <= '0;
            r_check_in     <= 8'h00;
            r_hits         <= 4'd0;
            r_fleet_lost   <= 1'b0;
            r_link_err     <= 1'b0;
`ifdef SHOT_RETRY_EN
            r_wait_cnt     <= '0;
            r_retry_cnt    <= 2'd0;
`endif
        end else begin
            r_tx_start <= 1'b0;
            r_as_q     <= addres_sent;

            case (r_rx_state)
                c_RX_IDLE: if (rx_valid && rx_data == c_HDR) r_rx_state <= c_RX_ADDR;
                default: begin
                    if (rx_valid) begin
                        r_rx_state   <= c_RX_IDLE;
                        r_pend_valid <= 1'b1;
                        r_pend_addr  <= rx_data;
                    end
                end
            endcase

            if (w_edge) begin
                r_req_valid <= 1'b1;
                r_req_addr  <= check_out;
            end

            if (r_msg_send != 2'b00) begin
                if (r_send_cnt == c_ONE) r_msg_send <= 2'b00;
                r_send_cnt <= r_send_cnt - c_ONE;
            end
            if (r_msg_in != 2'b00) begin
                if (r_in_cnt == c_ONE) r_msg_in <= 2'b00;
                r_in_cnt <= r_in_cnt - c_ONE;
            end

            // Byte handshake: wait idle, strobe, skip one busy sample, drain.
            if (w_tx_state) begin
                case (r_tx_phase)
                    c_PH_WAIT: begin
                        if (!tx_busy) begin
                            r_tx_start <= 1'b1;
                            r_tx_phase <= c_PH_SKIP;
                        end
                    end
                    c_PH_SKIP: r_tx_phase <= c_PH_DRAIN;
                    default: ;
                endcase
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (r_pend_valid) begin
                        if (!w_capture) r_pend_valid <= 1'b0;
                        r_cell_addr    <= r_pend_addr;
                        r_lookup_phase <= 1'b0;
                        r_state        <= c_ST_LOOKUP;
                    end else if (r_req_valid) begin
                        r_shot_addr <= r_req_addr;
                        r_req_valid <= w_edge;
                        r_tx_data   <= c_HDR;
                        r_tx_phase  <= c_PH_WAIT;
                        r_state     <= c_ST_TX_HDR;
`ifdef SHOT_RETRY_EN
                        r_retry_cnt <= 2'd0;
`endif
                    end
                end
                c_ST_TX_HDR: begin
                    if (w_tx_done) begin
                        r_tx_data  <= r_shot_addr;
                        r_tx_phase <= c_PH_WAIT;
                        r_state    <= c_ST_TX_ADDR;
                    end
                end
                c_ST_TX_ADDR: begin
                    if (w_tx_done) begin
                        r_state <= c_ST_WAIT_REPLY;
`ifdef SHOT_RETRY_EN
                        r_wait_cnt <= '0;
`endif
                    end
                end
                c_ST_WAIT_REPLY: begin
                    if (rx_valid && (rx_data == c_MISS || rx_data == c_HIT)) begin
                        r_msg_send <= (rx_data == c_HIT) ? 2'b10 : 2'b01;
                        r_send_cnt <= c_HOLD;
                        r_state    <= c_ST_IDLE;
                    end
`ifdef SHOT_RETRY_EN
                    else if (r_wait_cnt == c_TIMEOUT_LAST) begin
                        if (r_retry_cnt == 2'd3) begin
                            r_link_err <= 1'b1;
                            r_state    <= c_ST_IDLE;
                        end else begin
                            r_retry_cnt <= r_retry_cnt + 2'd1;
                            r_tx_data   <= c_HDR;
                            r_tx_phase  <= c_PH_WAIT;
                            r_state     <= c_ST_TX_HDR;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_ONE;
                    end
`endif
                end
                c_ST_LOOKUP: begin
                    // Board RAM answers one cycle after the address settles.
                    if (!r_lookup_phase) begin
                        r_lookup_phase <= 1'b1;
                    end else begin
                        r_check_in <= r_cell_addr;
                        r_msg_in   <= cell_ship ? 2'b10 : 2'b01;
                        r_in_cnt   <= c_HOLD;
                        if (cell_ship) begin
                            r_hits       <= (r_hits == 4'd11) ? 4'd11 : r_hits + 4'd1;
                            r_fleet_lost <= (r_hits >= 4'd10);
                        end
                        r_tx_data <= cell_ship ? c_HIT : c_MISS;
                        r_state   <= c_ST_TX_REPLY;
                        // Strobe straight away when the UART is free to keep reply latency short.
                        if (!tx_busy) begin
                            r_tx_start <= 1'b1;
                            r_tx_phase <= c_PH_SKIP;
                        end else begin
                            r_tx_phase <= c_PH_WAIT;
                        end
                    end
                end
                c_ST_TX_REPLY: begin
                    if (w_tx_done) begin
                        r_tx_phase <= c_PH_WAIT;
                        r_state    <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign tx_data    = r_tx_data;
    assign tx_start   = r_tx_start;
    assign cell_addr  = r_cell_addr;
    assign msg_send   = r_msg_send;
    assign msg_in     = r_msg_in;
    assign check_in   = r_check_in;
    assign hits_taken = r_hits;
    assign fleet_lost = r_fleet_lost;
    assign link_err   = r_link_err;

endmodule
`default_nettype wire

// File: tb/tb_shot_link.sv
`default_nettype none
// ============================================================================
// Module   : tb_shot_link
// Purpose  : Directed scoreboard bench for shot_link (UART and board models).
// Revision : 1.0  initial release
// ============================================================================
module tb_shot_link;

    localparam int HOLD = 20;
    localparam int TMO  = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       addres_sent = 1'b0;
    logic [7:0] check_out = 8'h00;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] cell_addr;
    logic       cell_ship = 1'b0;
    logic [1:0] msg_send;
    logic [1:0] msg_in;
    logic [7:0] check_in;
    logic [3:0] hits_taken;
    logic       fleet_lost;
    logic       link_err;

    always #5 clk = ~clk;

    shot_link #(.MSG_HOLD(HOLD), .REPLY_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .addres_sent(addres_sent), .check_out(check_out),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_valid(rx_valid), .cell_addr(cell_addr),
        .cell_ship(cell_ship), .msg_send(msg_send), .msg_in(msg_in),
        .check_in(check_in), .hits_taken(hits_taken), .fleet_lost(fleet_lost),
        .link_err(link_err)
    );

    // Own board as a synchronous RAM, UART as a fixed 4-cycle busy window.
    logic [255:0] board = '0;
    int           busy_cnt = 0;
    always @(posedge clk) begin
        cell_ship <= board[cell_addr];
        if (rst)              busy_cnt <= 0;
        else if (tx_start)    busy_cnt <= 4;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int tx_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && tx_start) begin
            tx_count++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL tx_unexpected: got 0x%0h expected no byte", tx_data);
            end else begin
                check("tx_byte", tx_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx_done(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || tx_busy) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) begin
            n_checks++;
            $display("FAIL %s_timeout: got %0d bytes pending expected 0", name, exp_q.size());
            exp_q.delete();
        end
        tick(2);
    endtask

    task automatic opp_shot(input logic [7:0] addr, input logic hit);
        exp_q.push_back(hit ? 8'hC1 : 8'hC0);
        send_rx(8'hA5);
        send_rx(addr);
        wait_tx_done("opp_shot");
    endtask

    task automatic check_reset_outs(input string name);
        check(name, {tx_start, tx_data, cell_addr, msg_send, msg_in, check_in,
                     hits_taken, fleet_lost, link_err}, 64'd0);
    endtask

    initial begin
        automatic logic [7:0] hit_addrs[11] = '{8'h52, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                                               8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
        int cnt;
        int lat;
        int tc;
        int t;

        tick(3);
        check_reset_outs("reset_outputs");
        rst = 1'b0;
        tick(2);

        // Our shot at 0x37, answered with a hit.
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h37);
        check_out   = 8'h37;
        addres_sent = 1'b1;
        wait_tx_done("shot_37");
        send_rx(8'hC1);
        check("msg_send_hit", msg_send, 2'b10);
        cnt = 0;
        while (msg_send == 2'b10 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("msg_send_hold_cycles", cnt, HOLD);
        check("msg_send_cleared", msg_send, 2'b00);
        addres_sent = 1'b0;

        // Opponent hit at 0x52, with reply latency measured.
        board[8'h52] = 1'b1;
        exp_q.push_back(8'hC1);
        send_rx(8'hA5);
        send_rx(8'h52);
        lat = 1;
        while (!tx_start && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("reply_latency_le4", lat <= 4, 1);
        check("cell_addr_52", cell_addr, 8'h52);
        check("check_in_52", check_in, 8'h52);
        check("msg_in_hit", msg_in, 2'b10);
        check("hits_after_52", hits_taken, 4'd1);
        wait_tx_done("reply_52");

        // Opponent miss at 0x11.
        opp_shot(8'h11, 1'b0);
        check("msg_in_miss", msg_in, 2'b01);
        check("check_in_11", check_in, 8'h11);
        check("hits_after_miss", hits_taken, 4'd1);

        // Eleven more hits (first repeats 0x52): saturation at 11.
        foreach (hit_addrs[k]) begin
            board[hit_addrs[k]] = 1'b1;
            opp_shot(hit_addrs[k], 1'b1);
            check("hits_count", hits_taken, (k + 2 > 11) ? 11 : k + 2);
            check("fleet_lost", fleet_lost, (k + 2 >= 11) ? 1 : 0);
        end

        // Opponent shot and our request land together: reply goes first.
        board[8'h24] = 1'b1;
        exp_q.push_back(8'hC1);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h68);
        send_rx(8'hA5);
        @(negedge clk);
        rx_data     = 8'h24;
        rx_valid    = 1'b1;
        check_out   = 8'h68;
        addres_sent = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        wait_tx_done("collide");
        send_rx(8'hC0);
        check("msg_send_miss", msg_send, 2'b01);
        check("hits_saturated", hits_taken, 4'd11);

        // Held level must not start another shot.
        tc = tx_count;
        tick(30);
        check("level_no_retrigger", tx_count, tc);

        // Reset between header and address; partial rx frame discarded.
        addres_sent = 1'b0;
        tick(2);
        send_rx(8'hA5);
        exp_q.push_back(8'hA5);
        check_out   = 8'h7E;
        addres_sent = 1'b1;
        tc = tx_count;
        t  = 0;
        while (tx_count == tc && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("hdr_before_reset", tx_count, tc + 1);
        rst = 1'b1;
        tick(2);
        check_reset_outs("reset_mid_frame");
        rst = 1'b0;
        board[8'h33] = 1'b1;
        tc = tx_count;
        send_rx(8'h33);
        tick(30);
        check("no_tx_after_reset", tx_count, tc);
        check_reset_outs("idle_after_reset");

        // Fresh shot after reset still works.
        addres_sent = 1'b0;
        tick(2);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h0F);
        check_out   = 8'h0F;
        addres_sent = 1'b1;
        wait_tx_done("shot_0f");
        send_rx(8'hC0);
        check("msg_send_after_reset", msg_send, 2'b01);

        // Unanswered shot.
        addres_sent = 1'b0;
        tick(2);
        tc = tx_count;
        check_out   = 8'h2B;
        addres_sent = 1'b1;
`ifdef SHOT_RETRY_EN
        repeat (4) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(8'h2B);
        end
        t = 0;
        while (!link_err && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("link_err_set", link_err, 1'b1);
        wait_tx_done("retry_frames");
        check("retry_byte_count", tx_count - tc, 8);
        opp_shot(8'h52, 1'b1);
        check("idle_after_link_err", check_in, 8'h52);
        check("link_err_sticky", link_err, 1'b1);
`else
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h2B);
        wait_tx_done("no_retry_frame");
        tick(4 * TMO);
        check("link_err_clear", link_err, 1'b0);
        check("no_resend", tx_count - tc, 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
